// File: rtl/logic_op_unit.sv
`default_nettype none
// ============================================================================
// logic_op_unit : registered WIDTH-bit OR/AND/XOR/NOR unit with accumulator
//                 and valid/ready handshake. Optional macro LOGIC_OP_PARITY_EN
//                 adds a registered parity output.  Rev 1.0
// ============================================================================
module logic_op_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             src_sel,
    input  logic [WIDTH-1:0] IN,
    input  logic [WIDTH-1:0] SV,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             zero,
    output logic [WIDTH-1:0] acc
`ifdef LOGIC_OP_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] w_opb, w_res, w_wval;
    logic             w_accept;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_opb = src_sel ? acc_q : SV;
        case (op)
            2'b00:   w_res = IN | w_opb;
            2'b01:   w_res = IN & w_opb;
            2'b10:   w_res = IN ^ w_opb;
            default: w_res = ~(IN | w_opb);
        endcase
        w_wval = en ? w_res : '0;
    end

    // Full with !out_ready cannot accept (in_ready=0), so it simply holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (w_accept) state_d = ST_FULL;
            default:  if (out_ready && !w_accept) state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_d  = out_q;
        zero_d = zero_q;
        acc_d  = acc_q;
        if (w_accept) begin
            out_d  = w_wval;
            zero_d = (w_wval == '0);
            if (en) acc_d = w_res;
        end
        // The clear takes priority over a same-cycle accumulator write.
        if (acc_clr) acc_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            zero_q  <= 1'b1;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            acc_q   <= acc_d;
        end
    end

    assign Out  = out_q;
    assign zero = zero_q;
    assign acc  = acc_q;

`ifdef LOGIC_OP_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (w_accept) parity_d = ^w_wval;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end

    assign parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_op_unit.sv
`default_nettype none
// ============================================================================
// tb_logic_op_unit : scoreboard bench for logic_op_unit (WIDTH=8).  Rev 1.0
// ============================================================================
module tb_logic_op_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, in_valid, in_ready, src_sel, acc_clr;
    logic       out_valid, out_ready, zero;
    logic [1:0] op;
    logic [7:0] IN, SV, Out, acc;
`ifdef LOGIC_OP_PARITY_EN
    logic       parity;
`endif

    int tests_run = 0;
    int tests_fail = 0;

    typedef struct {
        logic [7:0] out;
        logic       zero;
    } exp_t;
    exp_t exp_q[$];

    logic_op_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_sel(src_sel), .IN(IN), .SV(SV), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .zero(zero),
        .acc(acc)
`ifdef LOGIC_OP_PARITY_EN
        , .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at posedge+1; checks and monitor sample at negedge.
    task automatic issue(logic e, logic [1:0] o, logic s, logic [7:0] a,
                         logic [7:0] b, logic clr, logic [7:0] exp_out);
        int n;
        exp_t x;
        en = e; op = o; src_sel = s; IN = a; SV = b; acc_clr = clr;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            x.out  = exp_out;
            x.zero = (exp_out == 8'h00);
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; acc_clr = 1'b0;
        IN = 8'hxx; SV = 8'hxx;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {24'd0, Out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_out", {24'd0, Out}, {24'd0, e.out});
                    chk("sb_zero", {31'd0, zero}, {31'd0, e.zero});
`ifdef LOGIC_OP_PARITY_EN
                    chk("sb_parity", {31'd0, parity}, {31'd0, ^e.out});
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; src_sel = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b1; op = 2'b00; IN = 8'h00; SV = 8'h00;
        @(negedge clk);
        chk("rst_out", {24'd0, Out}, 32'h00);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_acc", {24'd0, acc}, 32'h00);
        @(posedge clk); #1 rst = 1'b0;

        // 1: reset asserted while a 0x3C result is held
        out_ready = 1'b0;
        issue(1'b1, 2'b00, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h3C);
        @(negedge clk);
        chk("hold_out_3c", {24'd0, Out}, 32'h3C);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_out", {24'd0, Out}, 32'h00);
        chk("arst_zero", {31'd0, zero}, 32'd1);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_acc", {24'd0, acc}, 32'h00);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // 2: OR
        issue(1'b1, 2'b00, 1'b0, 8'hA5, 8'h0F, 1'b0, 8'hAF);
        @(negedge clk);
        chk("or_acc", {24'd0, acc}, 32'hAF);
        @(posedge clk); #1;

        // 3: enable gating
        issue(1'b0, 2'b01, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00);
        @(negedge clk);
        chk("gate_acc", {24'd0, acc}, 32'hAF);
        @(posedge clk); #1;

        // 4: backpressure; AND with acc reproduces 0xAF
        out_ready = 1'b0;
        issue(1'b1, 2'b01, 1'b1, 8'hFF, 8'h00, 1'b0, 8'hAF);
        en = 1'b1; op = 2'b00; src_sel = 1'b0; IN = 8'h11; SV = 8'h00;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out", {24'd0, Out}, 32'hAF);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        exp_q.push_back('{out: 8'h11, zero: 1'b0});
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_acc", {24'd0, acc}, 32'h11);
        @(posedge clk); #1;
        issue(1'b1, 2'b00, 1'b0, 8'hAF, 8'h00, 1'b0, 8'hAF);

        // 5: accumulator chain
        issue(1'b1, 2'b10, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h50);
        @(negedge clk);
        chk("xor_acc", {24'd0, acc}, 32'h50);
        @(posedge clk); #1;
        issue(1'b1, 2'b11, 1'b1, 8'h0F, 8'h00, 1'b0, 8'hA0);
        @(negedge clk);
        chk("nor_acc", {24'd0, acc}, 32'hA0);
        @(posedge clk); #1;

        // 6: clear collides with accept, then clear alone under hold
        issue(1'b1, 2'b00, 1'b1, 8'h01, 8'h00, 1'b1, 8'hA1);
        out_ready = 1'b0;
        @(negedge clk);
        chk("clr_coll_acc", {24'd0, acc}, 32'h00);
        chk("clr_coll_out", {24'd0, Out}, 32'hA1);
        @(posedge clk); #1 acc_clr = 1'b1;
        @(posedge clk); #1 acc_clr = 1'b0;
        @(negedge clk);
        chk("clr_hold_acc", {24'd0, acc}, 32'h00);
        chk("clr_hold_out", {24'd0, Out}, 32'hA1);
        chk("clr_hold_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;

        // clear alone on a non-zero accumulator
        issue(1'b1, 2'b10, 1'b0, 8'h5A, 8'h00, 1'b0, 8'h5A);
        acc_clr = 1'b1;
        @(posedge clk); #1 acc_clr = 1'b0;
        @(negedge clk);
        chk("clr_alone_acc", {24'd0, acc}, 32'h00);
        chk("clr_alone_out", {24'd0, Out}, 32'h5A);
        chk("clr_alone_valid", {31'd0, out_valid}, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
`default_nettype wire
